// File: rtl/uart_tx_frame.sv
// uart_tx_frame
//   Parametrised UART transmit engine. Each valid/ready handshake accepts one
//   word. The word goes out as: start bit (0), DATA_BITS data bits LSB first,
//   an optional parity bit, then STOP_BITS stop bits (1). An internal baud
//   divider holds every bit for CLKS_PER_BIT clocks. The line idles high.
//
// Ports
//   clk       in   rising-edge clock
//   rst       in   synchronous active-high reset
//   tx_data   in   word to send, sampled only on handshake
//   tx_valid  in   producer has a word
//   tx_ready  out  engine can accept a word (registered, state == IDLE)
//   uart_tx   out  serial line (registered, idle 1)
//   tx_busy   out  frame on the line (registered, !tx_ready)
//   tx_done   out  one-cycle pulse in the first IDLE cycle after a frame
//
// States
//   state    | meaning
//   S_IDLE   | line high, waiting for tx_valid
//   S_START  | start bit (0) on the line
//   S_DATA   | data bits, LSB of shift register on the line
//   S_PARITY | parity bit on the line
//   S_STOP   | stop bit(s) (1); bit_cnt counts the stop bits
module uart_tx_frame #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 uart_tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_frame: DATA_BITS must be in 5..9");
    end
    if (CLKS_PER_BIT < 1) begin : g_bad_clks_per_bit
        $error("uart_tx_frame: CLKS_PER_BIT must be >= 1");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_frame: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_frame: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state, state_next;
    logic [BAUD_W-1:0]     baud_cnt, baud_next;
    logic [BIT_W-1:0]      bit_cnt, bit_next;
    logic [DATA_BITS-1:0]  shift_reg, shift_next;
    logic                  par_bit, par_next;
    logic                  line_next;
    logic                  done_next;
    logic                  baud_tc;

    // With CLKS_PER_BIT == 1 the counter stays at 0 and this is always true.
    assign baud_tc = (baud_cnt == BAUD_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            par_bit   <= 1'b0;
            uart_tx   <= 1'b1;
            tx_ready  <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_cnt   <= bit_next;
            shift_reg <= shift_next;
            par_bit   <= par_next;
            uart_tx   <= line_next;
            tx_ready  <= (state_next == S_IDLE);
            tx_busy   <= (state_next != S_IDLE);
            tx_done   <= done_next;
        end
    end

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        bit_next   = bit_cnt;
        shift_next = shift_reg;
        par_next   = par_bit;
        done_next  = 1'b0;

        // The baud counter only runs while a frame is on the line and is
        // cleared on every terminal count, so it never wraps on its own.
        if (state != S_IDLE) begin
            baud_next = baud_tc ? '0 : baud_cnt + BAUD_W'(1);
        end

        case (state)
            S_IDLE: begin
                if (tx_valid) begin
                    shift_next = tx_data;
                    par_next   = (^tx_data) ^ (PARITY == 2);
                    baud_next  = '0;
                    bit_next   = '0;
                    state_next = S_START;
                end
            end
            S_START: begin
                if (baud_tc) begin
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tc) begin
                    shift_next = {1'b0, shift_reg[DATA_BITS-1:1]};
                    if (bit_cnt == DATA_LAST) begin
                        bit_next   = '0;
                        state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        bit_next = bit_cnt + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (baud_tc) begin
                    bit_next   = '0;
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_tc) begin
                    if (bit_cnt == STOP_LAST) begin
                        bit_next   = '0;
                        done_next  = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        bit_next = bit_cnt + BIT_W'(1);
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Line value is derived from the upcoming state so uart_tx is a plain
    // register with no combinational path to the pad.
    always_comb begin
        line_next = 1'b1;
        case (state_next)
            S_START:  line_next = 1'b0;
            S_DATA:   line_next = shift_next[0];
            S_PARITY: line_next = par_next;
            default:  line_next = 1'b1;
        endcase
    end

endmodule
